mem_ctrl_arbiter: RTL and testbench
===================================

MEM_CTRL_ARBITER -- requirements
Module: mem_ctrl_arbiter

Interface
REQ-001 SHALL have parameter BLOCK_ADDR_W, default 29: main-memory block address width (32-bit address, 8-byte block).
REQ-002 SHALL have parameter BLOCK_W, default 64: block data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: number of lost dcache arbitrations before dcache wins; used only under REQ-029.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port icache_req_valid  input  1  icache block read request.
REQ-007 SHALL have port icache_req_ready  output  1  arbiter accepts icache request.
REQ-008 SHALL have port icache_req_block_addr  input  BLOCK_ADDR_W  icache block address.
REQ-009 SHALL have port icache_flush  input  1  fetch redirect; squash outstanding icache fill.
REQ-010 SHALL have port icache_resp_valid  output  1  fill data valid to icache.
REQ-011 SHALL have port dcache_req_valid  input  1  dcache request.
REQ-012 SHALL have port dcache_req_ready  output  1  arbiter accepts dcache request.
REQ-013 SHALL have port dcache_req_we  input  1  0 = block read, 1 = block write-back.
REQ-014 SHALL have port dcache_req_block_addr  input  BLOCK_ADDR_W  dcache block address.
REQ-015 SHALL have port dcache_req_block_data  input  BLOCK_W  write-back data.
REQ-016 SHALL have port dcache_resp_valid  output  1  fill data valid to dcache.
REQ-017 SHALL have port resp_block_data  output  BLOCK_W  fill data, shared by both caches.
REQ-018 SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1), mem_req_we (output, 1), mem_req_block_addr (output, BLOCK_ADDR_W) and mem_req_block_data (output, BLOCK_W): the main-memory request channel.
REQ-019 SHALL have ports mem_resp_valid (input, 1) and mem_resp_block_data (input, BLOCK_W): the main-memory response channel; busy (output, 1) is high when state != IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT_RESP, with at most one outstanding transaction.
REQ-021 SHALL assert icache_req_ready and dcache_req_ready only in IDLE, and to the granted requester only; a handshake occurs on valid && ready.
REQ-022 SHALL grant icache over dcache in IDLE when both are valid (strict priority, REQ-029 excepted).
REQ-023 SHALL, on grant, register owner, we, addr and data and move to REQ; mem_req_valid SHALL be asserted from the next cycle and held stable until mem_req_ready.
REQ-024 SHALL, in REQ with mem_req_ready high, go to IDLE if we=1 (write-back has no response) and to WAIT_RESP otherwise.
REQ-025 SHALL, in WAIT_RESP with mem_resp_valid high, assert owner's *_resp_valid combinationally in that cycle (unless squashed), pass mem_resp_block_data to resp_block_data, and go to IDLE.
REQ-026 SHALL treat mem_resp_valid outside WAIT_RESP as ignored, producing no resp_valid.
REQ-027 SHALL set the squash flag when icache_flush is high while owner=icache in REQ or WAIT_RESP, or in the same cycle as an icache grant; the squashed response is consumed with icache_resp_valid low; squash clears on return to IDLE; icache_flush in IDLE with no grant has no effect.
REQ-028 SHALL not squash dcache transactions on icache_flush.

Configuration
REQ-029 SHALL, with MEM_ARB_STARVE_GUARD_EN defined, keep a saturating counter incremented on each IDLE cycle where dcache_req_valid loses to icache; at count == STARVE_LIMIT dcache SHALL win the next IDLE arbitration, and the counter SHALL clear on dcache grant; without the macro, the counter SHALL be absent and strict icache priority applies.

Reset
REQ-030 SHALL on rst force IDLE, squash=0, counter=0; all valid/ready outputs 0 in the reset cycle; busy=0, data/addr outputs 0.
REQ-031 SHALL on rst mid-transaction abandon it; a later mem_resp_valid is ignored per REQ-026.

Verification
REQ-032 SHALL cover: icache read addr 0x10 at T, mem_req_ready at T+1, resp 0xDEADBEEF_CAFEF00D at T+4 -> icache_resp_valid=1 and data match at T+4; IDLE at T+5.
REQ-033 SHALL cover: both valid at T -> icache granted at T; dcache granted at the first IDLE cycle after the icache response.
REQ-034 SHALL cover: dcache write addr 0x20 data 0x1234 -> mem_req_we=1, IDLE one cycle after mem_req_ready; no resp_valid.
REQ-035 SHALL cover: icache_flush during WAIT_RESP -> response consumed, icache_resp_valid stays 0, next icache request served normally.
REQ-036 SHALL cover: with MEM_ARB_STARVE_GUARD_EN, icache and dcache valid continuously -> dcache granted after 4 icache grants; without the macro dcache never granted.
REQ-037 SHALL cover: rst asserted in WAIT_RESP -> IDLE next cycle, stale mem_resp_valid produces no resp_valid.

Source files
------------

// File: rtl/mem_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// mem_ctrl_arbiter
//
// Arbitrates the instruction cache and the data cache onto a single
// main-memory port. At most one transaction is in flight. Reads wait for a
// memory response, which is forwarded combinationally to the owning cache.
// Write-backs complete when memory accepts the request.
//
// icache has strict priority over dcache. A fetch redirect (icache_flush)
// squashes an in-flight icache fill. The memory response is still consumed,
// but it is not presented to the icache.
//
// Optional feature:
//   MEM_ARB_STARVE_GUARD_EN - when defined, a saturating counter tracks the
//   IDLE arbitrations that dcache loses to icache. Once the count reaches
//   STARVE_LIMIT, dcache wins the next IDLE arbitration. When the macro is
//   undefined, no counter is built and icache priority is strict.
//
// Parameters:
//   BLOCK_ADDR_W - block address width
//   BLOCK_W      - block data width
//   STARVE_LIMIT - number of lost dcache arbitrations before dcache is forced
//
// Ports:
//   clk, rst                     - clock; synchronous active-high reset
//   icache_req_valid/_ready      - icache read request handshake
//   icache_req_block_addr        - icache block address
//   icache_flush                 - fetch redirect; squashes the icache fill
//   icache_resp_valid            - fill data valid to the icache
//   dcache_req_valid/_ready      - dcache request handshake
//   dcache_req_we                - 0 = block read, 1 = block write-back
//   dcache_req_block_addr/_data  - dcache block address / write-back data
//   dcache_resp_valid            - fill data valid to the dcache
//   resp_block_data              - fill data shared by both caches
//   mem_req_*                    - main-memory request channel
//   mem_resp_valid/_block_data   - main-memory response channel
//   busy                         - a transaction is in progress
// -----------------------------------------------------------------------------
module mem_ctrl_arbiter #(
    parameter int BLOCK_ADDR_W = 29,
    parameter int BLOCK_W      = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    icache_req_valid,
    output logic                    icache_req_ready,
    input  logic [BLOCK_ADDR_W-1:0] icache_req_block_addr,
    input  logic                    icache_flush,
    output logic                    icache_resp_valid,
    input  logic                    dcache_req_valid,
    output logic                    dcache_req_ready,
    input  logic                    dcache_req_we,
    input  logic [BLOCK_ADDR_W-1:0] dcache_req_block_addr,
    input  logic [BLOCK_W-1:0]      dcache_req_block_data,
    output logic                    dcache_resp_valid,
    output logic [BLOCK_W-1:0]      resp_block_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_we,
    output logic [BLOCK_ADDR_W-1:0] mem_req_block_addr,
    output logic [BLOCK_W-1:0]      mem_req_block_data,
    input  logic                    mem_resp_valid,
    input  logic [BLOCK_W-1:0]      mem_resp_block_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    squash_q, squash_d;
    logic                    owner_q;   // 1 = dcache owns the transaction
    logic                    we_q;
    logic [BLOCK_ADDR_W-1:0] addr_q;
    logic [BLOCK_W-1:0]      data_q;

    logic in_idle;
    logic grant_ic;
    logic grant_dc;
    logic dcache_force;
    logic resp_hit;

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    // Grants are suppressed while reset is asserted, so no handshake can
    // occur in the reset cycle.
    assign in_idle  = (state_q == IDLE) && !rst;
    assign grant_dc = in_idle && dcache_req_valid && (!icache_req_valid || dcache_force);
    assign grant_ic = in_idle && icache_req_valid && !grant_dc;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign dcache_force = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_dc) begin
            starve_cnt_d = '0;
        end else if (grant_ic && dcache_req_valid &&
                     (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign dcache_force = 1'b0;
`endif

    // State register (the squash flag is part of the transaction state).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        unique case (state_q)
            IDLE: begin
                // A flush in the grant cycle already squashes the new fill.
                squash_d = grant_ic && icache_flush;
                if (grant_ic || grant_dc) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!owner_q && icache_flush) begin
                    squash_d = 1'b1;
                end
                if (mem_req_ready) begin
                    // A write-back gets no response from memory.
                    state_d = we_q ? IDLE : WAIT_RESP;
                    if (we_q) begin
                        squash_d = 1'b0;
                    end
                end
            end
            WAIT_RESP: begin
                if (!owner_q && icache_flush) begin
                    squash_d = 1'b1;
                end
                if (mem_resp_valid) begin
                    state_d  = IDLE;
                    squash_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                squash_d = 1'b0;
            end
        endcase
    end

    // The request is captured at grant and held until memory accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (grant_dc) begin
            owner_q <= 1'b1;
            we_q    <= dcache_req_we;
            addr_q  <= dcache_req_block_addr;
            data_q  <= dcache_req_block_data;
        end else if (grant_ic) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= icache_req_block_addr;
            data_q  <= '0;
        end
    end

    // Output logic.
    always_comb begin
        resp_hit           = !rst && (state_q == WAIT_RESP) && mem_resp_valid;
        icache_req_ready   = grant_ic;
        dcache_req_ready   = grant_dc;
        mem_req_valid      = !rst && (state_q == REQ);
        mem_req_we         = rst ? 1'b0 : we_q;
        mem_req_block_addr = rst ? '0 : addr_q;
        mem_req_block_data = rst ? '0 : data_q;
        // A flush that lands in the response cycle also hides the stale fill.
        icache_resp_valid  = resp_hit && !owner_q && !(squash_q || icache_flush);
        dcache_resp_valid  = resp_hit && owner_q;
        resp_block_data    = resp_hit ? mem_resp_block_data : '0;
        busy               = !rst && (state_q != IDLE);
    end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mem_ctrl_arbiter: directed vector table, a starvation sequence
// and randomized traffic checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_ctrl_arbiter;
    localparam int AW    = 29;
    localparam int DW    = 64;
    localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          icache_req_valid, icache_req_ready, icache_flush, icache_resp_valid;
    logic [AW-1:0] icache_req_block_addr;
    logic          dcache_req_valid, dcache_req_ready, dcache_req_we, dcache_resp_valid;
    logic [AW-1:0] dcache_req_block_addr;
    logic [DW-1:0] dcache_req_block_data, resp_block_data;
    logic          mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid, busy;
    logic [AW-1:0] mem_req_block_addr;
    logic [DW-1:0] mem_req_block_data, mem_resp_block_data;

    always #5 clk = ~clk;

    mem_ctrl_arbiter #(.BLOCK_ADDR_W(AW), .BLOCK_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
        .icache_req_block_addr(icache_req_block_addr), .icache_flush(icache_flush),
        .icache_resp_valid(icache_resp_valid),
        .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
        .dcache_req_we(dcache_req_we), .dcache_req_block_addr(dcache_req_block_addr),
        .dcache_req_block_data(dcache_req_block_data), .dcache_resp_valid(dcache_resp_valid),
        .resp_block_data(resp_block_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_block_addr(mem_req_block_addr), .mem_req_block_data(mem_req_block_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_block_data(mem_resp_block_data),
        .busy(busy)
    );

    typedef struct {
        logic          rst, iv;
        logic [AW-1:0] ia;
        logic          fl, dv, dwe;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          mrr, mrv;
        logic [DW-1:0] mrd;
    } in_t;

    typedef struct {
        in_t           in;
        logic          ir, dr, mv, mwe;
        logic [AW-1:0] maddr;
        logic          ivld, dvld, bsy;
        logic [DW-1:0] rdata;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference model: one transaction record plus the starvation count.
    bit            m_active = 1'b0;
    bit            m_issued = 1'b0;
    bit            m_dc = 1'b0;
    bit            m_we = 1'b0;
    bit            m_squash = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int            m_starve = 0;

    logic obs_ir, obs_dr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic rst_v, logic iv, logic [AW-1:0] ia, logic fl, logic dv,
                                logic dwe, logic [AW-1:0] da, logic [DW-1:0] dd, logic mrr,
                                logic mrv, logic [DW-1:0] mrd, logic ir, logic dr, logic mv,
                                logic mwe, logic [AW-1:0] maddr, logic ivld, logic dvld,
                                logic bsy, logic [DW-1:0] rdata);
        vec_t r;
        r.in.rst = rst_v; r.in.iv = iv; r.in.ia = ia; r.in.fl = fl; r.in.dv = dv;
        r.in.dwe = dwe; r.in.da = da; r.in.dd = dd; r.in.mrr = mrr; r.in.mrv = mrv;
        r.in.mrd = mrd;
        r.ir = ir; r.dr = dr; r.mv = mv; r.mwe = mwe; r.maddr = maddr;
        r.ivld = ivld; r.dvld = dvld; r.bsy = bsy; r.rdata = rdata;
        return r;
    endfunction

    // Drive one cycle of inputs, compare at the falling edge, advance the model
    // at the rising edge.
    task automatic step(input in_t v, input bit use_tbl, input vec_t e, input int row);
        bit idle, frc, gdc, gic, mv, hit;
        rst = v.rst; icache_req_valid = v.iv; icache_req_block_addr = v.ia;
        icache_flush = v.fl; dcache_req_valid = v.dv; dcache_req_we = v.dwe;
        dcache_req_block_addr = v.da; dcache_req_block_data = v.dd;
        mem_req_ready = v.mrr; mem_resp_valid = v.mrv; mem_resp_block_data = v.mrd;
        @(negedge clk);
        idle = !m_active;
        frc  = GUARD && (m_starve >= LIMIT);
        gdc  = !v.rst && idle && v.dv && (!v.iv || frc);
        gic  = !v.rst && idle && v.iv && !gdc;
        mv   = !v.rst && m_active && !m_issued;
        hit  = !v.rst && m_active && m_issued && v.mrv;
        chk("model_icache_req_ready", icache_req_ready, gic);
        chk("model_dcache_req_ready", dcache_req_ready, gdc);
        chk("model_mem_req_valid", mem_req_valid, mv);
        chk("model_busy", busy, !v.rst && m_active);
        chk("model_icache_resp_valid", icache_resp_valid, hit && !m_dc && !m_squash && !v.fl);
        chk("model_dcache_resp_valid", dcache_resp_valid, hit && m_dc);
        chk("model_resp_block_data", resp_block_data, hit ? v.mrd : 64'd0);
        if (v.rst) begin
            chk("model_rst_addr", mem_req_block_addr, 0);
            chk("model_rst_data", mem_req_block_data, 0);
            chk("model_rst_we", mem_req_we, 0);
        end else if (mv) begin
            chk("model_mem_req_addr", mem_req_block_addr, m_addr);
            chk("model_mem_req_data", mem_req_block_data, m_data);
            chk("model_mem_req_we", mem_req_we, m_we);
        end
        if (use_tbl) begin
            chk($sformatf("row%0d_icache_req_ready", row), icache_req_ready, e.ir);
            chk($sformatf("row%0d_dcache_req_ready", row), dcache_req_ready, e.dr);
            chk($sformatf("row%0d_mem_req_valid", row), mem_req_valid, e.mv);
            chk($sformatf("row%0d_mem_req_we", row), mem_req_we, e.mwe);
            chk($sformatf("row%0d_mem_req_addr", row), mem_req_block_addr, e.maddr);
            chk($sformatf("row%0d_icache_resp_valid", row), icache_resp_valid, e.ivld);
            chk($sformatf("row%0d_dcache_resp_valid", row), dcache_resp_valid, e.dvld);
            chk($sformatf("row%0d_busy", row), busy, e.bsy);
            chk($sformatf("row%0d_resp_data", row), resp_block_data, e.rdata);
        end
        obs_ir = icache_req_ready;
        obs_dr = dcache_req_ready;
        @(posedge clk);
        if (v.rst) begin
            m_active = 1'b0;
            m_starve = 0;
        end else if (!m_active) begin
            if (gdc) begin
                m_active = 1'b1; m_issued = 1'b0; m_dc = 1'b1; m_we = v.dwe;
                m_addr = v.da; m_data = v.dd; m_squash = 1'b0; m_starve = 0;
            end else if (gic) begin
                m_active = 1'b1; m_issued = 1'b0; m_dc = 1'b0; m_we = 1'b0;
                m_addr = v.ia; m_data = '0; m_squash = v.fl;
                if (v.dv && m_starve < LIMIT) m_starve++;
            end
        end else begin
            if (!m_dc && v.fl) m_squash = 1'b1;
            if (!m_issued) begin
                if (v.mrr) begin
                    if (m_we) m_active = 1'b0;
                    else m_issued = 1'b1;
                end
            end else if (v.mrv) begin
                m_active = 1'b0;
            end
        end
        #1;
    endtask

    vec_t tbl[$];
    vec_t none;
    in_t  v;
    int   ic_grants, dc_grants, first_dc;

    initial begin
        none = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
        // rst iv ia fl dv dwe da dd mrr mrv mrd | ir dr mv mwe maddr ivld dvld busy rdata
        tbl.push_back(mk(1,1,0,0,1,0,0,0,0,1,'h55,            0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,               0,0,0,0,0,0,0,0,0));
        // icache read 0x10, accepted at T+1, response at T+4
        tbl.push_back(mk(0,1,'h10,0,0,0,0,0,0,0,0,            1,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,               0,0,1,0,'h10,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,               0,0,0,0,'h10,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,               0,0,0,0,'h10,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,64'hDEADBEEF_CAFEF00D, 0,0,0,0,'h10,1,0,1,64'hDEADBEEF_CAFEF00D));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,               0,0,0,0,'h10,0,0,0,0));
        // dcache write-back 0x20 / 0x1234; stray response afterwards is ignored
        tbl.push_back(mk(0,0,0,0,1,1,'h20,'h1234,0,0,0,       0,1,0,0,'h10,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,               0,0,1,1,'h20,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,'hAA,            0,0,0,1,'h20,0,0,0,0));
        // icache fill squashed by a flush in WAIT_RESP, then a clean fill
        tbl.push_back(mk(0,1,'h30,0,0,0,0,0,0,0,0,            1,0,0,1,'h20,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,               0,0,1,0,'h30,0,0,1,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,0,0,0,0,               0,0,0,0,'h30,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,'h77,            0,0,0,0,'h30,0,0,1,'h77));
        tbl.push_back(mk(0,1,'h40,0,0,0,0,0,0,0,0,            1,0,0,0,'h30,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,               0,0,1,0,'h40,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,'h99,            0,0,0,0,'h40,1,0,1,'h99));
        // reset while waiting for a response; the late response is ignored
        tbl.push_back(mk(0,1,'h50,0,0,0,0,0,0,0,0,            1,0,0,0,'h40,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,               0,0,1,0,'h50,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,               0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,'hBB,            0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,'hBB,            0,0,0,0,0,0,0,0,0));
        // both valid: icache first, dcache on the first IDLE cycle after
        tbl.push_back(mk(0,1,'h60,0,1,0,'h61,0,0,0,0,         1,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,'h61,0,1,0,0,            0,0,1,0,'h60,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,1,0,'h61,0,0,1,'h11,         0,0,0,0,'h60,1,0,1,'h11));
        tbl.push_back(mk(0,0,0,0,1,0,'h61,0,0,0,0,            0,1,0,0,'h60,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,               0,0,1,0,'h61,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,'h22,            0,0,0,0,'h61,0,1,1,'h22));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,               0,0,0,0,'h61,0,0,0,0));

        rst = 1'b1; icache_req_valid = 0; icache_req_block_addr = '0; icache_flush = 0;
        dcache_req_valid = 0; dcache_req_we = 0; dcache_req_block_addr = '0;
        dcache_req_block_data = '0; mem_req_ready = 0; mem_resp_valid = 0;
        mem_resp_block_data = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].in, 1'b1, tbl[i], i);
        end

        // Both caches request continuously; memory accepts and answers at once.
        v = none.in;
        v.rst = 1'b1;
        step(v, 1'b0, none, 0);
        ic_grants = 0; dc_grants = 0; first_dc = -1;
        for (int c = 0; c < 40; c++) begin
            v = none.in;
            v.iv = 1'b1; v.dv = 1'b1; v.mrr = 1'b1; v.mrv = 1'b1;
            v.ia = AW'($urandom); v.da = AW'($urandom); v.mrd = {$urandom, $urandom};
            step(v, 1'b0, none, 0);
            if (obs_dr && first_dc < 0) first_dc = ic_grants;
            if (obs_ir) ic_grants++;
            if (obs_dr) dc_grants++;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("starve_icache_grants_before_dcache", 64'(first_dc), 64'(LIMIT));
`else
        chk("strict_dcache_grants", 64'(dc_grants), 0);
        chk("strict_icache_grants_enough", 64'(ic_grants >= 10), 1);
`endif

        // Randomized traffic against the reference model.
        for (int c = 0; c < 2500; c++) begin
            v.rst = ($urandom_range(0, 99) == 0);
            v.iv  = $urandom_range(0, 1);
            v.ia  = AW'($urandom);
            v.fl  = ($urandom_range(0, 9) == 0);
            v.dv  = $urandom_range(0, 1);
            v.dwe = $urandom_range(0, 1);
            v.da  = AW'($urandom);
            v.dd  = {$urandom, $urandom};
            v.mrr = $urandom_range(0, 1);
            v.mrv = ($urandom_range(0, 9) < 4);
            v.mrd = {$urandom, $urandom};
            step(v, 1'b0, none, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
